// File: rtl/tf_pkg.sv
// tf_pkg -- shared definitions for the twiddle-factor request scheduler.
//   CONF_NTT / CONF_INTT : legal mode codes sampled with start
//   TF_MODULUS           : modulus used by the downstream twiddle post-processor
//   state_t              : scheduler FSM encoding (also driven on dbg_state)
//   conf_legal()         : true when a conf code selects a supported mode
package tf_pkg;

    localparam logic [2:0] CONF_NTT  = 3'b001;
    localparam logic [2:0] CONF_INTT = 3'b011;

    localparam int unsigned TF_MODULUS = 3329;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic conf_legal(input logic [2:0] c);
        return (c == CONF_NTT) || (c == CONF_INTT);
    endfunction

endpackage

// File: rtl/tf_addr_gen.sv
// tf_addr_gen -- stage/index counters and twiddle address generation.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : begin a pass (s=0, k=0), latch i_load_intt as the mode
//   i_load_intt  : mode presented with i_load (1 = INTT)
//   i_adv        : current request accepted, move to the next (s,k)
//   i_clr        : drop the pass, counters and outputs back to zero
//   o_addr       : registered twiddle address 2^s + (k >> (LOG_N-1-s))
//   o_flag       : registered INTT pass-through flag, aligned with o_addr
//   o_last       : the request currently presented is the last of the pass
module tf_addr_gen
    import tf_pkg::*;
#(
    parameter int LOG_N  = 8,
    parameter int ADDR_W = LOG_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_intt,
    input  logic              i_adv,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_flag,
    output logic              o_last
);

    localparam int KW = LOG_N - 1;   // k spans 0..N/2-1
    localparam int SW = 4;           // s spans 0..LOG_N-1 with LOG_N <= 12

    localparam logic [KW-1:0] K_MAX = '1;
    localparam logic [SW-1:0] S_MAX = SW'(LOG_N - 1);

    logic [SW-1:0]     r_s;
    logic [KW-1:0]     r_k;
    logic              r_intt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_flag;

    logic              w_k_last;
    logic              w_s_last;
    logic [SW-1:0]     w_s_sel;
    logic [KW-1:0]     w_k_sel;
    logic              w_intt_sel;
    logic [LOG_N-1:0]  w_off;
    logic [LOG_N-1:0]  w_full;
    logic              w_flag;

    // k >> (LOG_N-1-s); past the final stage the value is meaningless
    // (the pass is being cleared), so return zero rather than shift by a
    // negative amount.
    function automatic logic [LOG_N-1:0] calc_off(input logic [SW-1:0] s,
                                                   input logic [KW-1:0] k);
        logic [SW-1:0] sh;
        if (s > S_MAX) begin
            return '0;
        end
        sh = S_MAX - s;
        return LOG_N'(k >> sh);
    endfunction

    // Outputs are registered, so the address of the *next* request is
    // computed here and loaded on start or accept.
    always_comb begin
        w_k_last = (r_k == K_MAX);
        w_s_last = (r_s == S_MAX);
        if (i_load) begin
            w_s_sel    = '0;
            w_k_sel    = '0;
            w_intt_sel = i_load_intt;
        end else begin
            w_k_sel    = w_k_last ? '0 : r_k + 1'b1;
            w_s_sel    = w_k_last ? r_s + 1'b1 : r_s;
            w_intt_sel = r_intt;
        end
        w_off  = calc_off(w_s_sel, w_k_sel);
        w_full = (LOG_N'(1) << w_s_sel) + w_off;
        w_flag = w_intt_sel & (w_off == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_k    <= '0;
            r_intt <= 1'b0;
            r_addr <= '0;
            r_flag <= 1'b0;
        end else if (i_clr) begin
            r_s    <= '0;
            r_k    <= '0;
            r_intt <= 1'b0;
            r_addr <= '0;
            r_flag <= 1'b0;
        end else if (i_load || i_adv) begin
            r_s    <= w_s_sel;
            r_k    <= w_k_sel;
            r_intt <= w_intt_sel;
            r_addr <= ADDR_W'(w_full);
            r_flag <= w_flag;
        end
    end

    assign o_addr = r_addr;
    assign o_flag = r_flag;
    assign o_last = w_k_last & w_s_last;

endmodule

// File: rtl/tf_sched.sv
// tf_sched -- twiddle-factor request scheduler for an NTT/INTT pass.
//   clk, rst    : clock, asynchronous active-high reset
//   start, conf : start a pass in IDLE; conf selects NTT (001) or INTT (011)
//   abort       : synchronous cancel of the pass in progress
//   out_ready   : downstream accepts a request this cycle
//   tf_valid    : tf_addr / proc_flag carry a request
//   tf_addr     : twiddle ROM address
//   proc_flag   : INTT pass-through select, aligned with tf_addr
//   busy        : pass in progress (RUN or DRAIN)
//   done        : one-cycle completion pulse, second DRAIN cycle
//   err         : one-cycle pulse after start with an unsupported conf
//   dbg_state   : current FSM state
//
// Handshake: a request transfers on a rising edge where tf_valid=1 and
// out_ready=1. While out_ready=0 the presented request (valid, address,
// flag) is held unchanged; tf_valid never drops without a transfer except
// on abort or reset.
module tf_sched
    import tf_pkg::*;
#(
    parameter int LOG_N  = 8,
    parameter int ADDR_W = LOG_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        conf,
    input  logic              abort,
    input  logic              out_ready,
    output logic              tf_valid,
    output logic [ADDR_W-1:0] tf_addr,
    output logic              proc_flag,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_drain_cnt;
    logic   w_drain_cnt_nxt;
    logic   r_valid;
    logic   r_busy;
    logic   r_done;
    logic   r_err;

    logic   w_accept;
    logic   w_last;
    logic   w_load;
    logic   w_adv;
    logic   w_clr;
    logic   w_done_nxt;
    logic   w_err_nxt;

    tf_addr_gen #(
        .LOG_N  (LOG_N),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_intt (conf == CONF_INTT),
        .i_adv       (w_adv),
        .i_clr       (w_clr),
        .o_addr      (tf_addr),
        .o_flag      (proc_flag),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_valid     <= (w_state_nxt == ST_RUN);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_load          = 1'b0;
        w_adv           = 1'b0;
        w_clr           = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_accept        = r_valid & out_ready;

        case (r_state)
            ST_IDLE: begin
                // abort in the same cycle drops the start entirely
                if (start && !abort) begin
                    if (conf_legal(conf)) begin
                        w_state_nxt = ST_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt     = ST_DRAIN;
                        w_drain_cnt_nxt = 1'b0;
                        w_clr           = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Two cycles cover the ROM read and post-processor latency;
                // done is registered so it lands in the second one.
                if (abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_drain_cnt_nxt = 1'b0;
                end else if (!r_drain_cnt) begin
                    w_drain_cnt_nxt = 1'b1;
                    w_done_nxt      = 1'b1;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_drain_cnt_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_drain_cnt_nxt = 1'b0;
            end
        endcase
    end

    assign tf_valid  = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tf_sched.sv
// tb_tf_sched -- self-checking bench for tf_sched with LOG_N=3 (N=8).
module tb_tf_sched;
    import tf_pkg::*;

    localparam int LOG_N  = 3;
    localparam int ADDR_W = 3;
    localparam int W      = ADDR_W + 1;
    localparam int NREQ   = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        conf;
    logic              abort;
    logic              out_ready;
    logic              tf_valid;
    logic [ADDR_W-1:0] tf_addr;
    logic              proc_flag;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbg_state;

    tf_sched #(.LOG_N(LOG_N), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .conf      (conf),
        .abort     (abort),
        .out_ready (out_ready),
        .tf_valid  (tf_valid),
        .tf_addr   (tf_addr),
        .proc_flag (proc_flag),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    int addr_tab  [NREQ] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int iflag_tab [NREQ] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};

    // results of the most recent drive_pass
    int       p_acc, p_done_cnt, p_done_gap, p_idle_gap;
    int       p_stall_chk, p_stall_bad, p_valid_late, p_timeout;
    logic     p_after_valid, p_after_busy;
    logic [7:0] p_rst_snap;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input bit intt, input int count);
        logic [ADDR_W-1:0] a;
        logic              f;
        for (int i = 0; i < count; i++) begin
            a = ADDR_W'(addr_tab[i]);
            f = intt && (iflag_tab[i] != 0);
            exp_q.push_back({f, a});
        end
    endtask

    // Runs one pass from IDLE and records what the DUT does.
    task automatic drive_pass(input logic [2:0] c, input bit rand_rdy,
                              input int abort_at, input int rst_at,
                              input int busy_start_at);
        int   cyc, idle_run, last_acc;
        bit   prev_stall, stopped, pending_after;
        logic [ADDR_W-1:0] prev_addr;
        logic prev_flag;
        p_acc = 0; p_done_cnt = 0; p_done_gap = -1; p_idle_gap = -1;
        p_stall_chk = 0; p_stall_bad = 0; p_valid_late = 0; p_timeout = 0;
        p_after_valid = 1'bx; p_after_busy = 1'bx; p_rst_snap = 8'hxx;
        obs_q.delete();
        start = 1'b1; conf = c;
        step();
        start = 1'b0;
        conf = (c == CONF_INTT) ? CONF_NTT : CONF_INTT;  // mode must stay latched
        cyc = 0; idle_run = 0; last_acc = -100;
        prev_stall = 0; stopped = 0; pending_after = 0;
        prev_addr = '0; prev_flag = 1'b0;
        while (idle_run < 4 && cyc < 300) begin
            abort = 1'b0;
            rst   = 1'b0;
            if (pending_after) begin
                p_after_valid = tf_valid;
                p_after_busy  = busy;
                pending_after = 0;
            end
            if (done) begin
                p_done_cnt++;
                p_done_gap = cyc - last_acc;
            end
            if (prev_stall) begin
                p_stall_chk++;
                if (tf_valid !== 1'b1 || tf_addr !== prev_addr || proc_flag !== prev_flag)
                    p_stall_bad++;
            end
            if (!busy && p_idle_gap < 0 && p_acc == NREQ) p_idle_gap = cyc - last_acc;
            if (tf_valid && p_acc == NREQ) p_valid_late++;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc == busy_start_at);
            if (tf_valid && abort_at > 0 && p_acc == abort_at - 1 && !stopped) begin
                abort = 1'b1; out_ready = 1'b0; stopped = 1; pending_after = 1;
            end else if (tf_valid && rst_at > 0 && p_acc == rst_at - 1 && !stopped) begin
                rst = 1'b1; out_ready = 1'b0; stopped = 1; pending_after = 1;
                #1;
                p_rst_snap = {tf_valid, tf_addr, proc_flag, busy, done, err};
            end
            prev_stall = tf_valid && !out_ready && !abort && !rst;
            if (tf_valid && out_ready) begin
                obs_q.push_back({proc_flag, tf_addr});
                p_acc++;
                last_acc = cyc;
            end
            prev_addr = tf_addr;
            prev_flag = proc_flag;
            idle_run = busy ? 0 : idle_run + 1;
            step();
            cyc++;
        end
        if (cyc >= 300) p_timeout = 1;
        start = 1'b0; abort = 1'b0; rst = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; conf = CONF_NTT; abort = 1'b0; out_ready = 1'b1;
        step(); step();
        n_cmp++;
        if ({tf_valid, tf_addr, proc_flag, busy, done, err} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {tf_valid, tf_addr, proc_flag, busy, done, err});
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        step(); step();
        n_cmp++;
        if (tf_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", tf_valid, busy);
        end
    endtask

    task automatic test_ntt();
        logic [W-1:0] e, o;
        push_expected(1'b0, NREQ);
        drive_pass(CONF_NTT, 1'b0, 0, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL ntt_seq: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL ntt_seq: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL ntt_extra: got %0d extra required 0", obs_q.size()); end
        n_cmp++;
        if (p_done_cnt != 1 || p_done_gap != 2) begin
            n_bad++; $display("FAIL ntt_done: got count %0d gap %0d required 1 2", p_done_cnt, p_done_gap);
        end
        n_cmp++;
        if (p_idle_gap != 3) begin n_bad++; $display("FAIL ntt_busy_drop: got %0d required 3", p_idle_gap); end
        n_cmp++;
        if (p_valid_late != 0 || p_timeout != 0) begin
            n_bad++; $display("FAIL ntt_drain: late valid %0d timeout %0d required 0 0", p_valid_late, p_timeout);
        end
    endtask

    task automatic test_intt();
        logic [W-1:0] e, o;
        push_expected(1'b1, NREQ);
        drive_pass(CONF_INTT, 1'b0, 0, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL intt_seq: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL intt_seq: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || p_done_cnt != 1 || p_done_gap != 2 || p_timeout != 0) begin
            n_bad++;
            $display("FAIL intt_end: extra %0d done %0d gap %0d timeout %0d required 0 1 2 0",
                     obs_q.size(), p_done_cnt, p_done_gap, p_timeout);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] e, o;
        push_expected(1'b1, NREQ);
        drive_pass(CONF_INTT, 1'b1, 0, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL stall_seq: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL stall_seq: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (p_stall_chk == 0 || p_stall_bad != 0) begin
            n_bad++; $display("FAIL stall_hold: %0d unstable of %0d stalls, required 0 of >0", p_stall_bad, p_stall_chk);
        end
        n_cmp++;
        if (obs_q.size() != 0 || p_done_cnt != 1 || p_done_gap != 2 || p_timeout != 0) begin
            n_bad++;
            $display("FAIL stall_end: extra %0d done %0d gap %0d timeout %0d required 0 1 2 0",
                     obs_q.size(), p_done_cnt, p_done_gap, p_timeout);
        end
    endtask

    task automatic test_bad_conf();
        logic [2:0] bad_codes [2] = '{3'b010, 3'b111};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; conf = bad_codes[i];
            step();
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || busy !== 1'b0 || tf_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL bad_conf_pulse: conf %b err=%b busy=%b valid=%b required 1 0 0",
                         bad_codes[i], err, busy, tf_valid);
            end
            step();
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b0 || tf_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
                n_bad++;
                $display("FAIL bad_conf_after: err=%b busy=%b valid=%b state=%0d required 0 0 0 0",
                         err, busy, tf_valid, dbg_state);
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] e, o;
        push_expected(1'b0, 4);
        drive_pass(CONF_NTT, 1'b0, 5, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL abort_seq: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL abort_seq: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (p_after_valid !== 1'b0 || p_after_busy !== 1'b0 || p_done_cnt != 0 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_stop: valid=%b busy=%b done %0d extra %0d required 0 0 0 0",
                     p_after_valid, p_after_busy, p_done_cnt, obs_q.size());
        end
        push_expected(1'b1, NREQ);
        drive_pass(CONF_INTT, 1'b0, 0, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL abort_rerun: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL abort_rerun: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (p_done_cnt != 1 || p_done_gap != 2) begin
            n_bad++; $display("FAIL abort_rerun_done: got %0d gap %0d required 1 2", p_done_cnt, p_done_gap);
        end
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] e, o;
        push_expected(1'b1, 6);
        drive_pass(CONF_INTT, 1'b0, 0, 7, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL rst_seq: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL rst_seq: got %h required %h", o, e); end
            end
        end
        n_cmp++;
        if (p_rst_snap !== 8'h00) begin
            n_bad++; $display("FAIL rst_outputs: got %b required 00000000", p_rst_snap);
        end
        n_cmp++;
        if (p_after_valid !== 1'b0 || p_after_busy !== 1'b0 || p_done_cnt != 0) begin
            n_bad++;
            $display("FAIL rst_stop: valid=%b busy=%b done %0d required 0 0 0",
                     p_after_valid, p_after_busy, p_done_cnt);
        end
        push_expected(1'b0, NREQ);
        drive_pass(CONF_NTT, 1'b0, 0, 0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL rst_rerun: missing request, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL rst_rerun: got %h required %h", o, e); end
            end
        end
    endtask

    task automatic test_busy_start();
        drive_pass(CONF_NTT, 1'b0, 0, 0, 3);
        n_cmp++;
        if (p_acc != NREQ) begin n_bad++; $display("FAIL busy_start_count: got %0d required %0d", p_acc, NREQ); end
        n_cmp++;
        if (p_done_cnt != 1 || p_valid_late != 0 || p_timeout != 0) begin
            n_bad++;
            $display("FAIL busy_start_end: done %0d late valid %0d timeout %0d required 1 0 0",
                     p_done_cnt, p_valid_late, p_timeout);
        end
    endtask

    task automatic test_abort_start();
        abort = 1'b1; start = 1'b1; conf = CONF_NTT;
        step();
        abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || tf_valid !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_start: busy=%b valid=%b err=%b required 0 0 0", busy, tf_valid, err);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || tf_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL abort_start_after: busy=%b valid=%b state=%0d required 0 0 0", busy, tf_valid, dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_stall();
        test_bad_conf();
        test_abort();
        test_rst_mid();
        test_busy_start();
        test_abort_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
